stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 124 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap controller with a DIV-cycle prescaler driving an external mod-60 counter chain.
// Optional auto-stop on chain overflow: define STOPWATCH_AUTO_STOP_EN.
module stopwatch_ctrl #(
  parameter int unsigned DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       ovf,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_hold,
  output logic [1:0] state,
  output logic       ovf_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          cnt_en_next, cnt_clr_next, lap_load_next, disp_hold_next, ovf_flag_next;
  logic          running, presc_last, auto_stop;

  assign running    = (state_reg == RUN) || (state_reg == LAP);
  assign presc_last = (presc_reg == PW'(DIV - 1));

`ifdef STOPWATCH_AUTO_STOP_EN
  assign auto_stop = ovf && running;
`else
  logic ovf_unused;
  assign ovf_unused = ovf;
  assign auto_stop  = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    presc_next     = presc_reg;
    cnt_clr_next   = 1'b0;
    lap_load_next  = 1'b0;
    disp_hold_next = disp_hold;
    ovf_flag_next  = ovf_flag;

    if (running)
      presc_next = presc_last ? '0 : presc_reg + PW'(1);

    case (state_reg)
      IDLE: begin
        if (clear) begin
          cnt_clr_next  = 1'b1;
          ovf_flag_next = 1'b0;
        end else if (start_stop) begin
          state_next = RUN;
          presc_next = '0;
        end
      end
      RUN, LAP: begin
        if (auto_stop) begin
          state_next     = PAUSE;
          disp_hold_next = 1'b0;
          ovf_flag_next  = 1'b1;
        end else if (start_stop) begin
          state_next     = PAUSE;
          disp_hold_next = 1'b0;
        end else if (lap) begin
          if (state_reg == RUN) begin
            state_next     = LAP;
            lap_load_next  = 1'b1;
            disp_hold_next = 1'b1;
          end else begin
            state_next     = RUN;
            disp_hold_next = 1'b0;
          end
        end
      end
      PAUSE: begin
        if (clear) begin
          state_next    = IDLE;
          presc_next    = '0;
          cnt_clr_next  = 1'b1;
          ovf_flag_next = 1'b0;
        end else if (start_stop) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase

    // A tick that coincides with leaving for PAUSE is dropped.
    cnt_en_next = running && presc_last && (state_next != PAUSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      lap_load  <= 1'b0;
      disp_hold <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      cnt_en    <= cnt_en_next;
      cnt_clr   <= cnt_clr_next;
      lap_load  <= lap_load_next;
      disp_hold <= disp_hold_next;
      ovf_flag  <= ovf_flag_next;
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl (DIV=4) against a behavioural model.
module tb_stopwatch_ctrl;
  localparam int DIV = 4;
`ifdef STOPWATCH_AUTO_STOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0, ovf = 1'b0;
  logic       cnt_en, cnt_clr, lap_load, disp_hold, ovf_flag;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 run, 2 pause, 3 lap; run_edges counts clocked edges spent running.
  int m_mode = 0;
  int run_edges = 0;
  bit m_en = 0, m_clr = 0, m_load = 0, m_hold = 0, m_flag = 0;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear), .ovf(ovf),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .lap_load(lap_load), .disp_hold(disp_hold),
    .state(state), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dut_vec();
    return {state, cnt_en, cnt_clr, lap_load, disp_hold, ovf_flag};
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [1:0] s = m_mode[1:0];
    return {s, m_en, m_clr, m_load, m_hold, m_flag};
  endfunction

  task automatic model_reset();
    m_mode = 0; run_edges = 0;
    m_en = 0; m_clr = 0; m_load = 0; m_hold = 0; m_flag = 0;
  endtask

  // One clock with the given commands; updates the model from the behavioural rules.
  task automatic step(input bit ss, input bit lp, input bit cl, input bit ov);
    bit was_run, to_pause;
    @(negedge clk);
    start_stop = ss; lap = lp; clear = cl; ovf = ov;
    @(posedge clk);
    #1;
    start_stop = 0; lap = 0; clear = 0; ovf = 0;
    was_run = (m_mode == 1) || (m_mode == 3);
    to_pause = 0;
    m_en = 0; m_clr = 0; m_load = 0;
    case (m_mode)
      0: if (cl) begin m_clr = 1; m_flag = 0; end
         else if (ss) begin m_mode = 1; run_edges = 0; end
      1, 3: if (AUTO && ov) begin m_mode = 2; m_hold = 0; m_flag = 1; to_pause = 1; end
            else if (ss) begin m_mode = 2; m_hold = 0; to_pause = 1; end
            else if (lp) begin
              if (m_mode == 1) begin m_mode = 3; m_load = 1; m_hold = 1; end
              else begin m_mode = 1; m_hold = 0; end
            end
      default: if (cl) begin m_mode = 0; m_clr = 1; m_flag = 0; run_edges = 0; end
               else if (ss) m_mode = 1;
    endcase
    if (was_run) begin
      run_edges++;
      if ((run_edges % DIV) == 0 && !to_pause) m_en = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec() !== 7'd0) begin
      n_bad++; $display("FAIL reset_state got=%b exp=%b", dut_vec(), 7'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL idle_ignore step %0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_run_ticks();
    int first = -1;
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0, 0);
      if (cnt_en && first < 0) first = i;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL run_tick cycle %0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (first !== 4) begin
      n_bad++; $display("FAIL first_tick got=%0d exp=%0d", first, 4);
    end
  endtask

  task automatic test_pause_resume();
    int lat = -1;
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      n_cmp++;
      if (cnt_en !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL pause_hold cycle %0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    step(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0);
      if (cnt_en && lat < 0) lat = i;
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL resume_latency got=%0d exp=%0d", lat, 2);
    end
    // Pause exactly on the terminal prescaler count drops that tick.
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    n_cmp++;
    if (cnt_en !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL pause_on_tick got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_lap();
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== 7'b11_0_0_1_1_0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL lap_enter got=%b exp=%b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL lap_count cycle %0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    step(0, 1, 0, 0);
    n_cmp++;
    if (state !== 2'd1 || disp_hold !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL lap_release got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    n_cmp++;
    if (state !== 2'd1 || cnt_clr !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL clear_in_run got=%b exp=%b", dut_vec(), exp_vec());
    end
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    n_cmp++;
    if (dut_vec() !== 7'b00_0_1_0_0_0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL pause_clear_ss got=%b exp=%b", dut_vec(), exp_vec());
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (cnt_clr !== 1'b0 || state !== 2'd0) begin
      n_bad++; $display("FAIL clr_one_cycle got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_ovf();
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    n_cmp++;
    if (dut_vec() !== exp_vec() || state !== (AUTO ? 2'd2 : 2'd3) || ovf_flag !== AUTO) begin
      n_bad++; $display("FAIL ovf_in_lap got=%b exp=%b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    n_cmp++;
    if (ovf_flag !== AUTO) begin
      n_bad++; $display("FAIL ovf_sticky got=%b exp=%b", ovf_flag, AUTO);
    end
    if (AUTO) begin
      step(0, 0, 1, 0);
      n_cmp++;
      if (ovf_flag !== 1'b0 || state !== 2'd0 || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ovf_clear got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    // Prescaler now at DIV-1: drop reset mid-cycle, well before the next edge.
    #1;
    rst = 0;
    #1;
    n_cmp++;
    if (dut_vec() !== 7'd0) begin
      n_bad++; $display("FAIL async_reset got=%b exp=%b", dut_vec(), 7'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      n_cmp++;
      if (cnt_en !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL post_reset cycle %0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int pick = $urandom_range(0, 9);
      bit ov = ($urandom_range(0, 15) == 0);
      step(pick == 0, pick == 1, pick == 2, ov);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random step %0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_pause_resume();
    test_lap();
    test_clear_priority();
    test_ovf();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
